hsv_core_retire_arb: RTL
========================

Name: hsv_core_retire_arb

Overview:
- Parametrised, in-order retirement arbiter for the core back end.
- Merges NUM_UNITS execution-unit result channels and retires them strictly in insn_token order.
- Drives the regfile write port and maintains the per-register pending mask (commit_mask) read by issue.
- On a trap it raises the core-wide flush handshake and collects NUM_FLUSH_ACKS acknowledgements.
- Generalises the fixed five-unit commit: unit count, token width and flush-ack count are parameters, and it adds pending-mask maintenance plus a sticky flush-ack collector.

Parameters:
NUM_UNITS, 5, number of execution-unit result channels (1..8)
TOKEN_W, 3, insn_token width; tokens wrap modulo 2^TOKEN_W
XLEN, 32, data/PC width
NUM_FLUSH_ACKS, 8, number of stages acknowledging flush

Ports:
clk_core  in  1  core clock
rst_core  in  1  synchronous active-high reset
unit_valid_i  in  NUM_UNITS  result valid per unit
unit_ready_o  out  NUM_UNITS  result accepted (combinational grant)
unit_token_i  in  NUM_UNITS*TOKEN_W  token of each result
unit_wr_en_i  in  NUM_UNITS  result writes rd
unit_rd_i  in  NUM_UNITS*5  destination register
unit_data_i  in  NUM_UNITS*XLEN  writeback data
unit_trap_i  in  NUM_UNITS  result is a trap
unit_target_i  in  NUM_UNITS*XLEN  flush target when trap
issue_set_i  in  1  issue marks rd pending this cycle
issue_rd_i  in  5  rd being marked
commit_mask_o  out  32  pending-write bit per register
token_o  out  TOKEN_W  next expected token
wr_en_o  out  1  regfile write enable
wr_addr_o  out  5  regfile write address
wr_data_o  out  XLEN  regfile write data
commit_unit_o  out  NUM_UNITS  one-hot unit retired last cycle
flush_req_o  out  1  flush request to all stages
flush_target_o  out  XLEN  restart PC
flush_ack_i  in  NUM_FLUSH_ACKS  per-stage flush acknowledge

Behaviour:
- Reset (synchronous, rst_core high at posedge): state RUN, token_o=0, commit_mask_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, commit_unit_o=0, flush_req_o=0, flush_target_o=0, ack collector cleared. Reset during FLUSH aborts the flush immediately.
- RUN, grant rule:
  - Candidate = unit with unit_valid_i=1 and unit_token_i==token_o.
  - unit_ready_o is asserted only for the candidate; at most one unit is granted per cycle.
  - Several matching units is a protocol error: the lowest index is granted, the others stall; the bench asserts this never occurs.
  - No candidate: all unit_ready_o=0, no state change.
- Grant with trap=0:
  - Next cycle: wr_en_o = granted unit_wr_en_i & (rd!=0), wr_addr_o=rd, wr_data_o=data, commit_unit_o=one-hot grant.
  - token_o increments modulo 2^TOKEN_W (2^TOKEN_W-1 → 0).
  - Latency: grant to regfile write is 1 cycle.
- Grant with trap=1:
  - No regfile write (wr_en_o=0); commit_unit_o still pulses.
  - Next cycle: flush_req_o=1, flush_target_o=unit_target_i, state → FLUSH.
- FLUSH:
  - All unit_ready_o=0; flush_req_o held high.
  - Each flush_ack_i bit is captured into a sticky register.
  - Exit when sticky|flush_ack_i is all ones. That cycle, next edge: flush_req_o=0, token_o=0, commit_mask_o=0, sticky cleared, state → RUN. Minimum FLUSH duration is 1 cycle.
  - issue_set_i is ignored in FLUSH.
- commit_mask_o:
  - Bit r is set on issue_set_i with issue_rd_i=r (r≠0).
  - Bit r is cleared when a non-trap retire writes r.
  - Set and clear of the same r in the same cycle: set wins (newer producer).
  - Bit 0 is always 0.
- wr_en_o and commit_unit_o are single-cycle pulses per retire.

Decomposition:
- hsv_core_pkg gains:
  - retire_state_t enum {RUN, FLUSH}
  - typedef retire_unit_t (token, wr_en, rd, data, trap, target) used to pack/unpack channels
  - localparam NUM_RETIRE_UNITS
- One sub-module, hsv_core_flush_collect:
  - Inputs: start, ack vector.
  - Maintains the sticky ack register.
  - Outputs: done.
- Grant, mask and token logic stay in the top.

Test Plan:
- In-order retire: units 0,2,1 present tokens 0,1,2 simultaneously → grants in 3 consecutive cycles: unit0, unit2, unit1. Writes x5=0x11, x6=0x22, x7=0x33. token_o ends at 3.
- Wrap: start at token_o=7, unit3 presents token 7 then token 0 → both retire and token_o goes 7→0→1. A unit presenting token 1 while token_o=7 stalls.
- Mask: issue_set rd=9 → bit 9 set. Retire writing x9 in the same cycle as issue_set rd=9 → bit 9 stays 1. A later retire of x9 with no set → bit 9 clears. issue_set rd=0 → mask unchanged.
- x0/no-write: retire with rd=0, wr_en=1 → wr_en_o=0, token_o still increments.
- Trap/flush: unit4 trap with target 0x0000_0100 → no write; flush_req_o=1 with flush_target_o=0x100. Acks arrive one per cycle in scattered order, bit 5 pulses only once → flush_req_o drops the cycle after the last bit; token_o=0, mask=0, unit_ready_o=0 throughout FLUSH.
- Reset mid-FLUSH: rst_core high for 1 cycle while in FLUSH → all outputs return to reset values the next cycle, state RUN.

Source files
------------

// File: rtl/hsv_core_pkg.sv
// Shared types and constants for the core back-end retirement path.
// Holds the retire FSM state encoding and the per-unit result record.
// Unit records use maximum field widths; narrower instances zero-extend.
package hsv_core_pkg;

  localparam int NUM_RETIRE_UNITS   = 5;
  localparam int RETIRE_TOKEN_W_MAX = 8;
  localparam int RETIRE_XLEN_MAX    = 64;
  localparam int RETIRE_RD_W        = 5;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } retire_state_t;

  // One execution-unit result, unpacked from the flat channel buses.
  typedef struct packed {
    logic [RETIRE_TOKEN_W_MAX-1:0] token;
    logic                          wr_en;
    logic [RETIRE_RD_W-1:0]        rd;
    logic [RETIRE_XLEN_MAX-1:0]    data;
    logic                          trap;
    logic [RETIRE_XLEN_MAX-1:0]    target;
  } retire_unit_t;

  // One-hot register mask for a destination register index.
  function automatic logic [31:0] rd_onehot(input logic [RETIRE_RD_W-1:0] rd);
    logic [31:0] m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/hsv_core_retire_arb_if.sv
// Execution-unit result channels into the retirement arbiter.
// master = execution units (drive results), slave = arbiter (drives ready).
// unit_ready_o is a combinational grant; a result is consumed on valid & ready.
interface hsv_core_retire_arb_if
  import hsv_core_pkg::*;
#(
  parameter int NUM_UNITS = NUM_RETIRE_UNITS,
  parameter int TOKEN_W   = 3,
  parameter int XLEN      = 32
);

  logic [NUM_UNITS-1:0]         unit_valid_i;
  logic [NUM_UNITS-1:0]         unit_ready_o;
  logic [NUM_UNITS*TOKEN_W-1:0] unit_token_i;
  logic [NUM_UNITS-1:0]         unit_wr_en_i;
  logic [NUM_UNITS*5-1:0]       unit_rd_i;
  logic [NUM_UNITS*XLEN-1:0]    unit_data_i;
  logic [NUM_UNITS-1:0]         unit_trap_i;
  logic [NUM_UNITS*XLEN-1:0]    unit_target_i;

  modport master (
    output unit_valid_i, unit_token_i, unit_wr_en_i, unit_rd_i,
           unit_data_i, unit_trap_i, unit_target_i,
    input  unit_ready_o
  );

  modport slave (
    input  unit_valid_i, unit_token_i, unit_wr_en_i, unit_rd_i,
           unit_data_i, unit_trap_i, unit_target_i,
    output unit_ready_o
  );

endinterface

// File: rtl/hsv_core_flush_collect.sv
// Sticky collector of per-stage flush acknowledgements.
// done is combinational: asserted in the cycle the last missing ack arrives.
// No backpressure; the sticky state clears whenever start drops or done fires.
module hsv_core_flush_collect
  import hsv_core_pkg::*;
#(
  parameter int NUM_FLUSH_ACKS = 8
) (
  input  logic                      clk_core,
  input  logic                      rst_core,
  input  logic                      start,
  input  logic [NUM_FLUSH_ACKS-1:0] ack,
  output logic                      done
);

  logic [NUM_FLUSH_ACKS-1:0] sticky_q;

  // Acks seen so far this flush plus the ones arriving now cover every stage.
  assign done = start && (&(sticky_q | ack));

  // Accumulate acks while a flush is outstanding; start fresh for the next one.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      sticky_q <= '0;
    end else if (!start || done) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_q | ack;
    end
  end

endmodule

// File: rtl/hsv_core_retire_arb.sv
// In-order retirement arbiter: grants the unit holding the expected token.
// Latency: grant to regfile write / flush request is 1 cycle.
// Only the token-matching unit sees ready; all units stall during a flush.
module hsv_core_retire_arb
  import hsv_core_pkg::*;
#(
  parameter int NUM_UNITS      = NUM_RETIRE_UNITS,
  parameter int TOKEN_W        = 3,
  parameter int XLEN           = 32,
  parameter int NUM_FLUSH_ACKS = 8
) (
  input  logic                      clk_core,
  input  logic                      rst_core,
  hsv_core_retire_arb_if.slave      units,
  input  logic                      issue_set_i,
  input  logic [4:0]                issue_rd_i,
  output logic [31:0]               commit_mask_o,
  output logic [TOKEN_W-1:0]        token_o,
  output logic                      wr_en_o,
  output logic [4:0]                wr_addr_o,
  output logic [XLEN-1:0]           wr_data_o,
  output logic [NUM_UNITS-1:0]      commit_unit_o,
  output logic                      flush_req_o,
  output logic [XLEN-1:0]           flush_target_o,
  input  logic [NUM_FLUSH_ACKS-1:0] flush_ack_i
);

  retire_state_t        state_q, state_d;
  logic [TOKEN_W-1:0]   token_q, token_d;
  logic [31:0]          mask_q, mask_d;
  logic                 wr_en_q, wr_en_d;
  logic [4:0]           wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]      wr_data_q, wr_data_d;
  logic [NUM_UNITS-1:0] commit_q, commit_d;
  logic [XLEN-1:0]      target_q, target_d;

  retire_unit_t         ch [NUM_UNITS];
  retire_unit_t         sel;
  logic [NUM_UNITS-1:0] grant;
  logic                 grant_any;
  logic                 flush_done;
  logic                 unused_sel;

  // Unpack the flat channel buses into one record per unit.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      ch[i]                     = '0;
      ch[i].token[TOKEN_W-1:0]  = units.unit_token_i[i*TOKEN_W +: TOKEN_W];
      ch[i].wr_en               = units.unit_wr_en_i[i];
      ch[i].rd                  = units.unit_rd_i[i*5 +: 5];
      ch[i].data[XLEN-1:0]      = units.unit_data_i[i*XLEN +: XLEN];
      ch[i].trap                = units.unit_trap_i[i];
      ch[i].target[XLEN-1:0]    = units.unit_target_i[i*XLEN +: XLEN];
    end
  end

  // Grant the lowest-index valid unit whose token is next in program order.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!grant_any && (state_q == RUN) && units.unit_valid_i[i] &&
          (ch[i].token[TOKEN_W-1:0] == token_q)) begin
        grant[i]  = 1'b1;
        grant_any = 1'b1;
      end
    end
  end

  assign units.unit_ready_o = grant;

  // Select the granted record; grant is one-hot or zero.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (grant[i]) begin
        sel = ch[i];
      end
    end
  end

  // Zero-extended upper field bits carry no information at narrow widths.
  assign unused_sel = ^sel;

  hsv_core_flush_collect #(
    .NUM_FLUSH_ACKS (NUM_FLUSH_ACKS)
  ) u_flush_collect (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .start    (state_q == FLUSH),
    .ack      (flush_ack_i),
    .done     (flush_done)
  );

  // Next-state, retire bookkeeping and pending-mask update.
  always_comb begin
    state_d   = state_q;
    token_d   = token_q;
    mask_d    = mask_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    commit_d  = '0;
    target_d  = target_q;

    unique case (state_q)
      RUN: begin
        if (grant_any) begin
          commit_d = grant;
          if (sel.trap) begin
            target_d = sel.target[XLEN-1:0];
            state_d  = FLUSH;
          end else begin
            wr_en_d   = sel.wr_en && (sel.rd != 5'd0);
            wr_addr_d = sel.rd;
            wr_data_d = sel.data[XLEN-1:0];
            token_d   = token_q + 1'b1;
            if (wr_en_d) begin
              mask_d = mask_q & ~rd_onehot(sel.rd);
            end
          end
        end
        // Applied after the clear so a same-cycle newer producer keeps the bit.
        if (issue_set_i && (issue_rd_i != 5'd0)) begin
          mask_d = mask_d | rd_onehot(issue_rd_i);
        end
      end
      FLUSH: begin
        if (flush_done) begin
          state_d = RUN;
          token_d = '0;
          mask_d  = '0;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    mask_d[0] = 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q   <= RUN;
      token_q   <= '0;
      mask_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      commit_q  <= '0;
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      token_q   <= token_d;
      mask_q    <= mask_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      commit_q  <= commit_d;
      target_q  <= target_d;
    end
  end

  assign commit_mask_o  = mask_q;
  assign token_o        = token_q;
  assign wr_en_o        = wr_en_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign commit_unit_o  = commit_q;
  assign flush_req_o    = (state_q == FLUSH);
  assign flush_target_o = target_q;

endmodule
